mac_array_stream: RTL

MAC_ARRAY_STREAM -- requirements
Module: mac_array_stream

---
 rtl/mac_array_stream.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mac_array_stream.sv
`default_nettype none
// ============================================================================
// mac_array_stream : C-channel signed streaming MAC with grouped accumulation,
// saturate/wrap selection, sticky overflow and full-pipeline backpressure.
// Revision: 1.0
// ============================================================================
module mac_array_stream #(
    parameter int C  = 4,
    parameter int WX = 8,
    parameter int WK = 8,
    parameter int WY = 32,
    parameter int LM = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_first,
    input  logic            s_last,
    input  logic [C*WX-1:0] s_x,
    input  logic [C*WK-1:0] s_k,
    input  logic            sat_en,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [C*WY-1:0] m_y,
    output logic [C-1:0]    m_ovf
);

    localparam int WP = WX + WK;
    localparam logic [WY-1:0] MAXV = {1'b0, {(WY-1){1'b1}}};
    localparam logic [WY-1:0] MINV = {1'b1, {(WY-1){1'b0}}};

    logic            en;
    logic [C*WP-1:0] prod_d;
    logic [C*WP-1:0] prod_q [LM];
    logic [LM-1:0]   pv_q, pf_q, pl_q, ps_q;

    logic [C*WY-1:0] acc_q, acc_d;
    logic [C-1:0]    ovf_q, ovf_d;
    logic            after_last_q;
    logic            done_q;

    logic            m_valid_q;
    logic [C*WY-1:0] m_y_q;
    logic [C-1:0]    m_ovf_q;

    logic            t_valid, t_first, t_last, t_sat, seed;

    assign en      = !m_valid_q || m_ready;
    assign s_ready = en && !rst;

    assign t_valid = pv_q[LM-1];
    assign t_first = pf_q[LM-1];
    assign t_last  = pl_q[LM-1];
    assign t_sat   = ps_q[LM-1];
    // Restart from zero on an explicit first beat or after a finished group / reset.
    assign seed    = t_first || after_last_q;

    for (genvar i = 0; i < C; i++) begin : g_ch
        logic signed [WP-1:0] prod_tail;
        logic signed [WY:0]   base;
        logic signed [WY:0]   sum;
        logic                 ovf_now;

        assign prod_d[i*WP +: WP] = $signed(s_x[i*WX +: WX]) * $signed(s_k[i*WK +: WK]);
        assign prod_tail = $signed(prod_q[LM-1][i*WP +: WP]);
        assign base      = seed ? '0 : $signed({acc_q[i*WY+WY-1], acc_q[i*WY +: WY]});
        assign sum       = base + prod_tail;
        assign ovf_now   = sum[WY] ^ sum[WY-1];
        assign acc_d[i*WY +: WY] = (ovf_now && t_sat) ? (sum[WY] ? MINV : MAXV) : sum[WY-1:0];
        assign ovf_d[i]  = (!seed && ovf_q[i]) || ovf_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
        end else if (en) begin
            pv_q[0] <= s_valid;
            for (int j = 1; j < LM; j++) pv_q[j] <= pv_q[j-1];
        end
    end

    // Payload needs no reset: it is only consumed alongside its valid bit.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_q[0] <= prod_d;
            pf_q[0]   <= s_first;
            pl_q[0]   <= s_last;
            ps_q[0]   <= sat_en;
            for (int j = 1; j < LM; j++) begin
                prod_q[j] <= prod_q[j-1];
                pf_q[j]   <= pf_q[j-1];
                pl_q[j]   <= pl_q[j-1];
                ps_q[j]   <= ps_q[j-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            ovf_q        <= '0;
            after_last_q <= 1'b1;
            done_q       <= 1'b0;
        end else if (en) begin
            done_q <= t_valid && t_last;
            if (t_valid) begin
                acc_q        <= acc_d;
                ovf_q        <= ovf_d;
                after_last_q <= t_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_y_q     <= '0;
            m_ovf_q   <= '0;
        end else if (en) begin
            m_valid_q <= done_q;
            if (done_q) begin
                m_y_q   <= acc_q;
                m_ovf_q <= ovf_q;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_y     = m_y_q;
    assign m_ovf   = m_ovf_q;

endmodule
`default_nettype wire
